// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle RISC-V M-extension unit covering MUL, MULH, MULHSU,
// MULHU, DIV, DIVU, REM and REMU at width XLEN. It uses a radix-2 shift-add
// multiplier and a restoring divider, and both share one FSM and one counter.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   in_valid / in_ready   request handshake; in_ready = (state==IDLE) & ~rst
//   op                    funct3: 000 MUL .. 111 REMU
//   operand1, operand2    rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   flush                 synchronous kill of any in-flight or pending operation
//   out_valid / out_ready response handshake
//   result, zero_flag     registered result and (result == 0)
module alu_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_s1, r_s2;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_b;          // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [2*XLEN-1:0] r_acc;        // product accumulator (mul) or {remainder, quotient} (div)
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;

    logic              w_s1, w_s2, w_special;
    logic [XLEN-1:0]   w_mag1, w_mag2, w_spec_res;
    logic [XLEN:0]     w_sum, w_diff;
    logic [2*XLEN-1:0] w_next, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_fix_res;

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero_flag = r_zero;

    // Request decode: signs, magnitudes and the division special cases
    always_comb begin
        logic w_div0, w_ovf;
        w_s1 = operand1[XLEN-1] &
               ((op == 3'b000) | (op == 3'b001) | (op == 3'b010) | (op[2] & ~op[0]));
        w_s2 = operand2[XLEN-1] & ((op == 3'b001) | (op[2] & ~op[0]));
        w_mag1 = w_s1 ? -operand1 : operand1;
        w_mag2 = w_s2 ? -operand2 : operand2;
        w_div0 = (operand2 == '0);
        w_ovf  = ~op[0] & (operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (operand2 == '1);
        w_special = op[2] & (w_div0 | w_ovf);
        if (w_div0)
            w_spec_res = op[1] ? operand1 : '1;
        else
            w_spec_res = op[1] ? '0 : operand1;
    end

    // One iteration: shift-add step for multiply, restoring step for divide
    always_comb begin
        w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : '0)};
        w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
        w_next = '0;
        if (!r_op[2])
            w_next = {w_sum, r_acc[XLEN-1:1]};
        else if (w_diff[XLEN])
            w_next = {r_acc[2*XLEN-2:0], 1'b0};
        else
            w_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    // Sign correction and result selection
    always_comb begin
        w_prod = (r_s1 ^ r_s2) ? -r_acc : r_acc;
        w_quot = (r_s1 ^ r_s2) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_s1 ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (r_op[2])
            w_fix_res = r_op[1] ? w_rem : w_quot;
        else if (r_op[1:0] == 2'b00)
            w_fix_res = w_prod[XLEN-1:0];
        else
            w_fix_res = w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_cnt       <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op  <= op;
                        r_s1  <= w_s1;
                        r_s2  <= w_s2;
                        r_cnt <= CW'(XLEN);
                        if (w_special) begin
                            // Special result parked in the accumulator; DONE publishes it
                            r_acc   <= {{XLEN{1'b0}}, w_spec_res};
                            r_state <= DONE;
                        end else begin
                            r_b     <= op[2] ? w_mag2 : w_mag1;
                            r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_mag1 : w_mag2)};
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_result    <= w_fix_res;
                    r_zero      <= (w_fix_res == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // Entered with out_valid low only from the special-case path:
                    // raise it one cycle after accept; out_ready is ignored meanwhile.
                    if (!r_out_valid) begin
                        r_result    <= r_acc[XLEN-1:0];
                        r_zero      <= (r_acc[XLEN-1:0] == '0);
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
